pipe_stall_ctrl: RTL and testbench

Parametrised pipeline stall controller for the processor core. It produces one synchronous enable per pipeline stage rather than gated clocks. It inserts programmable wait states for program-memory and data-memory accesses that fall in the slow (external) address region, and it honours an external hold request. It also keeps a saturating count of fetch-stall cycles for performance monitoring.

---
 rtl/pipe_stall_ctrl_pkg.sv | 15 +
 rtl/pipe_stall_ctrl_wait_timer.sv | 43 ++++
 rtl/pipe_stall_ctrl.sv | 96 +++++++++
 tb/tb_pipe_stall_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared defaults and the slow-region address decode for the pipeline stall controller.
// Addresses at or above the slow base live in external memory and need wait states.
package pipe_stall_pkg;

   localparam int              MAX_ADDR_W    = 64;
   localparam logic [15:0]     DEF_SLOW_BASE = 16'h1000;
   localparam int              DEF_CNT_W     = 4;
   localparam int              DEF_STAT_W    = 16;

   function automatic logic is_slow(input logic [MAX_ADDR_W-1:0] addr,
                                    input logic [MAX_ADDR_W-1:0] base);
      return (addr >= base);
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_wait_timer.sv
// One wait-state timer: a down-counter loaded on a slow access plus a done flag
// that masks the still-presented access until its stage has actually advanced.
module wait_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trig,
   input  logic [CNT_W-1:0] wait_val,
   input  logic             stage_en_i,
   output logic             o_busy
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic             w_load;

   // A zero wait value never loads, so it can neither stall nor set done.
   assign w_load = trig && stage_en_i && (r_cnt == '0) && !r_done && (wait_val != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         if (w_load) begin
            r_cnt <= wait_val;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end

         // Set on the 1->0 step; held through hold until the stage really moves.
         if (r_cnt == CNT_W'(1)) begin
            r_done <= 1'b1;
         end else if (r_done && stage_en_i) begin
            r_done <= 1'b0;
         end
      end
   end

   assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: per-stage advance enables driven by PM/DM wait timers
// and an external hold, plus a saturating fetch-stall cycle counter.
module pipe_stall_ctrl
   import pipe_stall_pkg::*;
#(
   parameter int                NUM_STAGES = 4,
   parameter int                DM_STAGE   = 2,
   parameter int                ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] SLOW_BASE  = ADDR_W'(DEF_SLOW_BASE),
   parameter int                PM_WAIT    = 2,
   parameter int                DM_RD_WAIT = 3,
   parameter int                DM_WR_WAIT = 1,
   parameter int                CNT_W      = DEF_CNT_W,
   parameter int                STAT_W     = DEF_STAT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hold_req,
   input  logic                  pm_req,
   input  logic [ADDR_W-1:0]     pm_add,
   input  logic                  dm_req,
   input  logic [ADDR_W-1:0]     dm_add,
   input  logic                  rwb,
   input  logic                  stat_clr,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic                  pm_wait,
   output logic                  dm_wait,
   output logic [STAT_W-1:0]     stall_cycles
);

   logic [NUM_STAGES-1:0] w_stage_en;
   logic                  w_pm_trig;
   logic                  w_dm_trig;
   logic [CNT_W-1:0]      w_dm_wait_val;
   logic                  w_pm_busy;
   logic                  w_dm_busy;
   logic [STAT_W-1:0]     r_stall_cycles;

   assign w_pm_trig     = pm_req && is_slow(MAX_ADDR_W'(pm_add), MAX_ADDR_W'(SLOW_BASE));
   assign w_dm_trig     = dm_req && is_slow(MAX_ADDR_W'(dm_add), MAX_ADDR_W'(SLOW_BASE));
   assign w_dm_wait_val = rwb ? CNT_W'(DM_RD_WAIT) : CNT_W'(DM_WR_WAIT);

   wait_timer #(
      .CNT_W      (CNT_W)
   ) u_pm_timer (
      .clk        (clk),
      .rst        (rst),
      .trig       (w_pm_trig),
      .wait_val   (CNT_W'(PM_WAIT)),
      .stage_en_i (w_stage_en[0]),
      .o_busy     (w_pm_busy)
   );

   wait_timer #(
      .CNT_W      (CNT_W)
   ) u_dm_timer (
      .clk        (clk),
      .rst        (rst),
      .trig       (w_dm_trig),
      .wait_val   (w_dm_wait_val),
      .stage_en_i (w_stage_en[DM_STAGE]),
      .o_busy     (w_dm_busy)
   );

   // A DM wait freezes fetch through the DM stage; later stages drain into a bubble.
   always_comb begin
      w_stage_en = '1;
      if (!rst || hold_req) begin
         w_stage_en = '0;
      end else if (w_dm_busy) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (i <= DM_STAGE) begin
               w_stage_en[i] = 1'b0;
            end
         end
      end else if (w_pm_busy) begin
         w_stage_en[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cycles <= '0;
      end else if (stat_clr) begin
         r_stall_cycles <= '0;
      end else if (!w_stage_en[0] && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   assign stage_en     = w_stage_en;
   assign pm_wait      = rst && w_pm_busy;
   assign dm_wait      = rst && w_dm_busy;
   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl: the driver queues the expected
// outputs of each cycle, a monitor compares them mid-cycle.
module tb_pipe_stall_ctrl;

   logic        clk;
   logic        rst;
   logic        hold_req;
   logic        pm_req;
   logic [15:0] pm_add;
   logic        dm_req;
   logic [15:0] dm_add;
   logic        rwb;
   logic        stat_clr;
   logic [3:0]  stage_en;
   logic        pm_wait;
   logic        dm_wait;
   logic [15:0] stall_cycles;
   logic [3:0]  stage_en4;
   logic        pm_wait4;
   logic        dm_wait4;
   logic [3:0]  stall_cycles4;

   typedef struct {
      logic [3:0] en;
      logic       pw;
      logic       dw;
      int         st;
      int         st4;
      int         id;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc_id = 0;

   pipe_stall_ctrl u_dut (
      .clk(clk), .rst(rst), .hold_req(hold_req), .pm_req(pm_req), .pm_add(pm_add),
      .dm_req(dm_req), .dm_add(dm_add), .rwb(rwb), .stat_clr(stat_clr),
      .stage_en(stage_en), .pm_wait(pm_wait), .dm_wait(dm_wait),
      .stall_cycles(stall_cycles)
   );

   pipe_stall_ctrl #(.STAT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .hold_req(hold_req), .pm_req(pm_req), .pm_add(pm_add),
      .dm_req(dm_req), .dm_add(dm_add), .rwb(rwb), .stat_clr(stat_clr),
      .stage_en(stage_en4), .pm_wait(pm_wait4), .dm_wait(dm_wait4),
      .stall_cycles(stall_cycles4)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int id, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, id, act, exp);
      end
   endtask

   // Monitor: outputs are combinational from state, so sample at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("stage_en", e.id, int'(stage_en), int'(e.en));
            check("pm_wait", e.id, int'(pm_wait), int'(e.pw));
            check("dm_wait", e.id, int'(dm_wait), int'(e.dw));
            if (e.st >= 0) check("stall_cycles", e.id, int'(stall_cycles), e.st);
            if (e.st4 >= 0) check("stall_cycles_w4", e.id, int'(stall_cycles4), e.st4);
         end
      end
   end

   task automatic cyc(input bit r, input bit h, input bit pr, input logic [15:0] pa,
                      input bit dr, input logic [15:0] da, input bit rw, input bit cl,
                      input logic [3:0] en, input bit pw, input bit dw,
                      input int st, input int st4);
      exp_t e;
      rst = r; hold_req = h; pm_req = pr; pm_add = pa;
      dm_req = dr; dm_add = da; rwb = rw; stat_clr = cl;
      cyc_id++;
      e.en = en; e.pw = pw; e.dw = dw; e.st = st; e.st4 = st4; e.id = cyc_id;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int guard;
      // reset
      cyc(0,0, 0,16'h0000, 0,16'h0000,1,0, 4'b0000,0,0, -1,-1);
      cyc(0,0, 0,16'h0000, 0,16'h0000,1,0, 4'b0000,0,0,  0, 0);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0,  0, 0);
      // slow fetch, address held through the release cycle
      cyc(1,0, 1,16'h1FFF, 0,16'h0000,1,0, 4'b1111,0,0,  0, 0);
      cyc(1,0, 1,16'h1FFF, 0,16'h0000,1,0, 4'b1110,1,0,  0, 0);
      cyc(1,0, 1,16'h1FFF, 0,16'h0000,1,0, 4'b1110,1,0,  1, 1);
      cyc(1,0, 1,16'h1FFF, 0,16'h0000,1,0, 4'b1111,0,0,  2, 2);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0,  2, 2);
      // fast fetch just below the slow base
      cyc(1,0, 1,16'h0FFF, 0,16'h0000,1,0, 4'b1111,0,0, -1,-1);
      cyc(1,0, 1,16'h0FFF, 0,16'h0000,1,0, 4'b1111,0,0, -1,-1);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0,  2, 2);
      // slow DM read
      cyc(1,0, 0,16'h0000, 1,16'h2000,1,0, 4'b1111,0,0,  2, 2);
      cyc(1,0, 0,16'h0000, 1,16'h2000,1,0, 4'b1000,0,1, -1,-1);
      cyc(1,0, 0,16'h0000, 1,16'h2000,1,0, 4'b1000,0,1, -1,-1);
      cyc(1,0, 0,16'h0000, 1,16'h2000,1,0, 4'b1000,0,1, -1,-1);
      cyc(1,0, 0,16'h0000, 1,16'h2000,1,0, 4'b1111,0,0,  5, 5);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0,  5, 5);
      // slow DM write
      cyc(1,0, 0,16'h0000, 1,16'h2000,0,0, 4'b1111,0,0,  5, 5);
      cyc(1,0, 0,16'h0000, 1,16'h2000,0,0, 4'b1000,0,1,  5, 5);
      cyc(1,0, 0,16'h0000, 1,16'h2000,0,0, 4'b1111,0,0,  6, 6);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0,  6, 6);
      // simultaneous slow fetch and slow read
      cyc(1,0, 1,16'h1FFF, 1,16'h2000,1,0, 4'b1111,0,0,  6, 6);
      cyc(1,0, 1,16'h1FFF, 1,16'h2000,1,0, 4'b1000,1,1,  6, 6);
      cyc(1,0, 1,16'h1FFF, 1,16'h2000,1,0, 4'b1000,1,1,  7, 7);
      cyc(1,0, 1,16'h1FFF, 1,16'h2000,1,0, 4'b1000,0,1,  8, 8);
      cyc(1,0, 1,16'h1FFF, 1,16'h2000,1,0, 4'b1111,0,0,  9, 9);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0,  9, 9);
      // hold while the DM counter is at 2
      cyc(1,0, 0,16'h0000, 1,16'h2000,1,0, 4'b1111,0,0,  9, 9);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1000,0,1,  9, 9);
      cyc(1,1, 0,16'h0000, 0,16'h0000,1,0, 4'b0000,0,1, 10,10);
      cyc(1,1, 0,16'h0000, 0,16'h0000,1,0, 4'b0000,0,1, 11,11);
      cyc(1,1, 0,16'h0000, 0,16'h0000,1,0, 4'b0000,0,0, 12,12);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0, 13,13);
      // reset while the DM counter is at 2
      cyc(1,0, 0,16'h0000, 1,16'h2000,1,0, 4'b1111,0,0, 13,13);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1000,0,1, 13,13);
      cyc(0,0, 0,16'h0000, 0,16'h0000,1,0, 4'b0000,0,0, 14,14);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0,  0, 0);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0,  0, 0);
      // statistics: 20 hold cycles, 4-bit copy saturates at 15
      for (int i = 0; i < 20; i++) begin
         cyc(1,1, 0,16'h0000, 0,16'h0000,1,0, 4'b0000,0,0, i, (i > 15) ? 15 : i);
      end
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,1, 4'b1111,0,0, 20,15);
      cyc(1,1, 0,16'h0000, 0,16'h0000,1,1, 4'b0000,0,0,  0, 0);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0,  0, 0);
      cyc(1,0, 0,16'h0000, 0,16'h0000,1,0, 4'b1111,0,0,  0, 0);

      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      n_cmp++;
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
